sram_fifo_ctrl: RTL and testbench

//  Synchronous FIFO controller driving the team's simple dual-port SRAM (1 write port, 1 registered

---
 rtl/sram_fifo_ctrl.sv | 141 ++++++++++++++
 tb/tb_sram_fifo_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// sram_fifo_ctrl
//
// Synchronous FIFO controller sitting directly upstream of a simple dual-port
// SRAM. The SRAM has one write port and one registered read port with a
// 1-cycle read latency. On a same-address read/write it returns the old data.
//
// The write side turns a valid/ready stream into SRAM write commands. The read
// side issues SRAM reads ahead of the consumer. It re-times the registered
// SRAM q into a 2-entry output buffer, so out_data/out_valid come straight from
// flops. Sustained rate is one word per clock in each direction.
//
// Ports
//   clk        clock, all logic on posedge
//   rst        synchronous active-high reset
//   in_data    write-side word
//   in_valid   write-side word present
//   in_ready   controller accepts word (transfer on in_valid & in_ready)
//   out_data   read-side word, head of the output buffer
//   out_valid  out_data valid
//   out_ready  consumer takes word (transfer on out_valid & out_ready)
//   mem_we     SRAM write enable
//   mem_waddr  SRAM write address
//   mem_wdata  SRAM write data
//   mem_raddr  SRAM read address
//   mem_q      SRAM read data, valid the cycle after mem_raddr
//   mem_count  words held in the SRAM (excludes in-flight read and buffer)
// -----------------------------------------------------------------------------
module sram_fifo_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic [ADDR_WIDTH:0]   mem_count
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH + 1)'(DEPTH);

    // Stage 0: SRAM pointers and occupancy
    logic [ADDR_WIDTH-1:0] wr_ptr_p0;
    logic [ADDR_WIDTH-1:0] rd_ptr_p0;
    logic [ADDR_WIDTH:0]   cnt_p0;

    // Stage 1: read issued last cycle, mem_q carries its word now
    logic                  vld_p1;

    // Stage 2: output buffer, entry 0 is the head
    logic [DATA_WIDTH-1:0] ob_data0_p2;
    logic [DATA_WIDTH-1:0] ob_data1_p2;
    logic [1:0]            ob_cnt_p2;

    logic                  accept;
    logic                  pop;
    logic                  rd_issue;
    logic [1:0]            ob_cnt_next;
    logic [1:0]            ob_wr_slot;
    logic [ADDR_WIDTH:0]   cnt_next;

    function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
        return p + 1'b1;
    endfunction

    always_comb begin
        in_ready  = !rst && (cnt_p0 != FULL_CNT);
        accept    = in_valid && in_ready;
        out_valid = (ob_cnt_p2 != 2'd0);
        out_data  = ob_data0_p2;
        pop       = out_valid && out_ready;

        mem_we    = accept;
        mem_waddr = wr_ptr_p0;
        mem_wdata = in_data;
        mem_raddr = rd_ptr_p0;
        mem_count = cnt_p0;

        // Buffer occupancy next cycle, counting the word already in flight.
        // ob_cnt + vld never exceeds 2, so this cannot wrap.
        ob_cnt_next = ob_cnt_p2 + {1'b0, vld_p1} - {1'b0, pop};

        // Only issue a read if its word is guaranteed a buffer slot. Because
        // the count is registered, a word written this cycle is not yet
        // visible here, so a same-address read/write is never issued.
        rd_issue = !rst && (cnt_p0 != '0) && (ob_cnt_next < 2'd2);

        // Slot the arriving SRAM word lands in, after any pop shifts the head
        ob_wr_slot = ob_cnt_p2 - {1'b0, pop};

        cnt_next = cnt_p0;
        case ({accept, rd_issue})
            2'b10:   cnt_next = cnt_p0 + 1'b1;
            2'b01:   cnt_next = cnt_p0 - 1'b1;
            default: cnt_next = cnt_p0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_p0 <= '0;
            rd_ptr_p0 <= '0;
            cnt_p0    <= '0;
            vld_p1    <= 1'b0;
            ob_cnt_p2 <= 2'd0;
        end else begin
            if (accept)
                wr_ptr_p0 <= ptr_inc(wr_ptr_p0);
            if (rd_issue)
                rd_ptr_p0 <= ptr_inc(rd_ptr_p0);
            cnt_p0    <= cnt_next;
            vld_p1    <= rd_issue;
            ob_cnt_p2 <= ob_cnt_next;
            // A full buffer receiving a word without a pop would lose data.
            assert (!(vld_p1 && !pop && ob_cnt_p2 == 2'd2));
        end
    end

    // Buffer data is not reset: ob_cnt_p2 decides what is valid.
    always_ff @(posedge clk) begin
        if (pop)
            ob_data0_p2 <= ob_data1_p2;
        if (vld_p1) begin
            if (ob_wr_slot == 2'd0)
                ob_data0_p2 <= mem_q;
            else
                ob_data1_p2 <= mem_q;
        end
    end

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
module tb_sram_fifo_ctrl;

    localparam int DW = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic [AW-1:0] mem_raddr;
    logic [DW-1:0] mem_q;
    logic [AW:0]   mem_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_raddr(mem_raddr), .mem_q(mem_q), .mem_count(mem_count)
    );

    // Simple dual-port SRAM model: registered read, old data on collision
    logic [DW-1:0] sram [2**AW];
    always @(posedge clk) begin
        if (mem_we) sram[mem_waddr] <= mem_wdata;
        mem_q <= sram[mem_raddr];
    end

    // One clock: drive inputs, sample handshakes at negedge, end at posedge+1
    task automatic tick(input logic iv, input logic [DW-1:0] id, input logic ordy,
                        output logic acc, output logic pp, output logic ov,
                        output logic [DW-1:0] od);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        @(negedge clk);
        acc = in_valid & in_ready;
        ov  = out_valid;
        pp  = out_valid & out_ready;
        od  = out_data;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %0b want 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        checks++; if (mem_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", mem_count); end
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready: got %0b want 1", in_ready); end
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b0;
        @(negedge clk);
        checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL single_we: got %0b want 1", mem_we); end
        checks++; if (mem_waddr !== 3'd0) begin errors++; $display("FAIL single_waddr: got %0d want 0", mem_waddr); end
        checks++; if (mem_wdata !== 8'hA5) begin errors++; $display("FAIL single_wdata: got %0h want a5", mem_wdata); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (mem_count !== 4'd1) begin errors++; $display("FAIL single_count_t1: got %0d want 1", mem_count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_ov_t1: got %0b want 0", out_valid); end
        @(posedge clk); #1;
        checks++; if (mem_count !== 4'd0) begin errors++; $display("FAIL single_count_t2: got %0d want 0", mem_count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_ov_t2: got %0b want 0", out_valid); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_ov_t3: got %0b want 1", out_valid); end
        checks++; if (out_data !== 8'hA5) begin errors++; $display("FAIL single_data: got %0h want a5", out_data); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drained: got %0b want 0", out_valid); end
    endtask

    task automatic test_fill();
        logic acc, pp, ov;
        logic [DW-1:0] od;
        int word = 0;
        int exp  = 0;
        for (int c = 0; c < 20; c++) begin
            tick(1'b1, DW'(word), 1'b0, acc, pp, ov, od);
            if (acc) word++;
        end
        in_valid = 1'b0;
        checks++; if (word !== 10) begin errors++; $display("FAIL fill_accepted: got %0d want 10", word); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready: got %0b want 0", in_ready); end
        checks++; if (mem_count !== 4'd8) begin errors++; $display("FAIL fill_count: got %0d want 8", mem_count); end
        tick(1'b0, '0, 1'b1, acc, pp, ov, od);
        checks++; if (!(pp === 1'b1 && od === 8'd0)) begin errors++; $display("FAIL fill_first: got pop=%0b data=%0h want 1/0", pp, od); end
        if (pp) exp = 1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_back: got %0b want 1", in_ready); end
        checks++; if (mem_count !== 4'd7) begin errors++; $display("FAIL fill_count_after: got %0d want 7", mem_count); end
        for (int c = 0; c < 40 && exp < 10; c++) begin
            tick(1'b0, '0, 1'b1, acc, pp, ov, od);
            if (pp) begin
                checks++; if (od !== DW'(exp)) begin errors++; $display("FAIL fill_order: got %0h want %0h", od, exp); end
                exp++;
            end
        end
        checks++; if (exp !== 10) begin errors++; $display("FAIL fill_drain_count: got %0d want 10", exp); end
        tick(1'b0, '0, 1'b1, acc, pp, ov, od);
        checks++; if (ov !== 1'b0) begin errors++; $display("FAIL fill_extra_word: got out_valid %0b want 0", ov); end
    endtask

    task automatic test_stream();
        logic acc, pp, ov;
        logic [DW-1:0] od;
        logic [DW-1:0] sb[$];
        int low = 0;
        int outs = 0;
        for (int c = 0; c < 1000; c++) begin
            tick(1'b1, DW'(c), 1'b1, acc, pp, ov, od);
            if (!acc) low++;
            else sb.push_back(DW'(c));
            if (pp) begin
                outs++;
                checks++;
                if (sb.size() == 0 || od !== sb[0]) begin errors++; $display("FAIL stream_data: got %0h", od); end
                if (sb.size() != 0) void'(sb.pop_front());
            end
        end
        checks++; if (low !== 0) begin errors++; $display("FAIL stream_in_ready_low: got %0d cycles want 0", low); end
        checks++; if (outs !== 997) begin errors++; $display("FAIL stream_rate: got %0d words want 997", outs); end
        for (int c = 0; c < 20 && sb.size() != 0; c++) begin
            tick(1'b0, '0, 1'b1, acc, pp, ov, od);
            if (pp) begin
                checks++;
                if (od !== sb[0]) begin errors++; $display("FAIL stream_tail: got %0h want %0h", od, sb[0]); end
                void'(sb.pop_front());
            end
        end
        checks++; if (sb.size() !== 0) begin errors++; $display("FAIL stream_leftover: got %0d want 0", sb.size()); end
    endtask

    task automatic test_random();
        logic acc, pp, ov, iv, ordy;
        logic [DW-1:0] od, id;
        logic [DW-1:0] sb[$];
        logic hold = 1'b0;
        logic [DW-1:0] hold_data = '0;
        int sent = 0;
        int got  = 0;
        for (int c = 0; c < 60000 && got < 5000; c++) begin
            iv   = (sent < 5000) && ($urandom_range(99, 0) < 50);
            ordy = ($urandom_range(99, 0) < 30);
            id   = DW'($urandom);
            tick(iv, id, ordy, acc, pp, ov, od);
            if (hold) begin
                checks++;
                if (ov !== 1'b1 || od !== hold_data) begin errors++; $display("FAIL rand_hold: got %0b/%0h want 1/%0h", ov, od, hold_data); end
            end
            hold = ov && !ordy;
            hold_data = od;
            if (acc) begin sb.push_back(id); sent++; end
            if (pp) begin
                checks++;
                if (sb.size() == 0 || od !== sb[0]) begin errors++; $display("FAIL rand_data: got %0h at word %0d", od, got); end
                if (sb.size() != 0) void'(sb.pop_front());
                got++;
            end
        end
        checks++; if (got !== 5000) begin errors++; $display("FAIL rand_timeout: got %0d words want 5000", got); end
    endtask

    task automatic test_collision();
        logic acc, pp, ov;
        logic [DW-1:0] od;
        logic [DW-1:0] want[3] = '{8'h51, 8'h52, 8'h53};
        int k = 0;
        for (int i = 0; i < 3; i++) tick(1'b1, DW'(8'h50 + i), 1'b0, acc, pp, ov, od);
        for (int i = 0; i < 4; i++) tick(1'b0, '0, 1'b0, acc, pp, ov, od);
        checks++; if (mem_count !== 4'd1) begin errors++; $display("FAIL coll_count_pre: got %0d want 1", mem_count); end
        checks++; if (out_data !== 8'h50) begin errors++; $display("FAIL coll_head: got %0h want 50", out_data); end
        tick(1'b1, 8'h53, 1'b1, acc, pp, ov, od);
        checks++; if (!(acc === 1'b1 && pp === 1'b1 && od === 8'h50)) begin errors++; $display("FAIL coll_xfer: got acc=%0b pop=%0b data=%0h want 1/1/50", acc, pp, od); end
        checks++; if (mem_count !== 4'd1) begin errors++; $display("FAIL coll_count_post: got %0d want 1", mem_count); end
        for (int c = 0; c < 20 && k < 3; c++) begin
            tick(1'b0, '0, 1'b1, acc, pp, ov, od);
            if (pp) begin
                checks++;
                if (od !== want[k]) begin errors++; $display("FAIL coll_data: got %0h want %0h", od, want[k]); end
                k++;
            end
        end
        checks++; if (k !== 3) begin errors++; $display("FAIL coll_drain: got %0d words want 3", k); end
    endtask

    task automatic test_reset_mid();
        logic acc, pp, ov;
        logic [DW-1:0] od;
        int n = 0;
        logic [DW-1:0] first = '0;
        for (int i = 0; i < 8; i++) tick(1'b1, DW'(8'h60 + i), 1'b0, acc, pp, ov, od);
        for (int i = 0; i < 3; i++) tick(1'b0, '0, 1'b0, acc, pp, ov, od);
        checks++; if (mem_count !== 4'd6) begin errors++; $display("FAIL rmid_count_pre: got %0d want 6", mem_count); end
        tick(1'b0, '0, 1'b1, acc, pp, ov, od);
        checks++; if (mem_count !== 4'd5) begin errors++; $display("FAIL rmid_count_issue: got %0d want 5", mem_count); end
        rst = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rmid_in_ready: got %0b want 0", in_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_out_valid: got %0b want 0", out_valid); end
        checks++; if (mem_count !== 4'd0) begin errors++; $display("FAIL rmid_count: got %0d want 0", mem_count); end
        tick(1'b1, 8'h3C, 1'b0, acc, pp, ov, od);
        for (int c = 0; c < 10; c++) begin
            tick(1'b0, '0, 1'b1, acc, pp, ov, od);
            if (pp) begin
                if (n == 0) first = od;
                n++;
            end
        end
        checks++; if (n !== 1) begin errors++; $display("FAIL rmid_words: got %0d want 1", n); end
        checks++; if (first !== 8'h3C) begin errors++; $display("FAIL rmid_data: got %0h want 3c", first); end
    endtask

    initial begin
        for (int i = 0; i < 2**AW; i++) sram[i] = 8'hEE;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        test_reset();
        test_single();
        test_fill();
        test_stream();
        test_random();
        test_collision();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
